// File: rtl/regfile_scoreboard_pkg.sv
//==============================================================================
// Module      : regfile_scoreboard_pkg
// Description : Shared register-file types and constants for the scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package regfile_scoreboard_pkg;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO      = 5'd0;
    localparam int        NUM_ARCH_REGS = 32;

endpackage : regfile_scoreboard_pkg

`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
//==============================================================================
// Module      : regfile_scoreboard_if
// Description : Issue, writeback and status bundle between decode/WB and scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface regfile_scoreboard_if #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rs1;
    logic [ADDR_WIDTH-1:0] issue_rs2;
    logic                  issue_use_rs1;
    logic                  issue_use_rs2;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic                  issue_wr_en;
    logic                  issue_ready;
    logic                  wb0_valid;
    logic [ADDR_WIDTH-1:0] wb0_rd;
    logic                  wb1_valid;
    logic [ADDR_WIDTH-1:0] wb1_rd;
    logic [NUM_REGS-1:0]   busy_mask;
    logic [ADDR_WIDTH:0]   outstanding;
    logic [CNT_WIDTH-1:0]  stall_cycles;
    logic                  err;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_rd, issue_wr_en, wb0_valid, wb0_rd, wb1_valid, wb1_rd,
        input  issue_ready, busy_mask, outstanding, stall_cycles, err
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_rd, issue_wr_en, wb0_valid, wb0_rd, wb1_valid, wb1_rd,
        output issue_ready, busy_mask, outstanding, stall_cycles, err
    );

endinterface : regfile_scoreboard_if

`default_nettype wire

// File: rtl/regfile_scoreboard_popcount.sv
//==============================================================================
// Module      : regfile_scoreboard_popcount
// Description : Combinational population count of a bit vector.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_scoreboard_popcount #(
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 6
) (
    input  wire logic [WIDTH-1:0]     i_vec,
    output logic      [OUT_WIDTH-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_count = o_count + OUT_WIDTH'(i_vec[i]);
        end
    end

endmodule : regfile_scoreboard_popcount

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
//==============================================================================
// Module      : regfile_scoreboard
// Description : Busy-bit scoreboard stalling issue on RAW/WAW until writeback.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int NUM_REGS      = NUM_ARCH_REGS,
    parameter int ADDR_WIDTH    = $clog2(NUM_REGS),
    parameter int RETIRE_BYPASS = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    regfile_scoreboard_if.slave sb
);

    localparam logic [ADDR_WIDTH-1:0] c_zero = ADDR_WIDTH'(REG_ZERO);

    logic [NUM_REGS-1:0]  busy_q, busy_d;
    logic [ADDR_WIDTH:0]  outstanding_q, outstanding_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic                 err_q, err_d;

    logic [NUM_REGS-1:0]  w_retiring;
    logic [NUM_REGS-1:0]  w_eff_busy;
    logic [NUM_REGS-1:0]  w_set;
    logic                 w_hazard;
    logic                 w_orphan0;
    logic                 w_orphan1;
    logic                 w_dual;

    always_comb begin
        w_retiring = '0;
        if (sb.wb0_valid) w_retiring[sb.wb0_rd] = 1'b1;
        if (sb.wb1_valid) w_retiring[sb.wb1_rd] = 1'b1;
        w_retiring[0] = 1'b0;
    end

    // With bypass, a register retiring this cycle no longer blocks issue.
    if (RETIRE_BYPASS != 0) begin : g_bypass
        assign w_eff_busy = busy_q & ~w_retiring;
    end else begin : g_no_bypass
        assign w_eff_busy = busy_q;
    end

    always_comb begin
        w_hazard = (sb.issue_use_rs1 && (sb.issue_rs1 != c_zero) && w_eff_busy[sb.issue_rs1])
                || (sb.issue_use_rs2 && (sb.issue_rs2 != c_zero) && w_eff_busy[sb.issue_rs2])
                || (sb.issue_wr_en   && (sb.issue_rd  != c_zero) && w_eff_busy[sb.issue_rd]);

        w_set = '0;
        if (sb.issue_valid && !w_hazard && sb.issue_wr_en) w_set[sb.issue_rd] = 1'b1;
        w_set[0] = 1'b0;

        busy_d    = (busy_q & ~w_retiring) | w_set;
        busy_d[0] = 1'b0;

        w_orphan0 = sb.wb0_valid && (sb.wb0_rd != c_zero) && !busy_q[sb.wb0_rd];
        w_orphan1 = sb.wb1_valid && (sb.wb1_rd != c_zero) && !busy_q[sb.wb1_rd];
        w_dual    = sb.wb0_valid && sb.wb1_valid && (sb.wb0_rd == sb.wb1_rd)
                 && (sb.wb0_rd != c_zero);
        err_d     = err_q || w_orphan0 || w_orphan1 || w_dual;

        stall_d = stall_q;
        if (sb.issue_valid && w_hazard && (stall_q != '1)) begin
            stall_d = stall_q + CNT_WIDTH'(1);
        end
    end

    // Count the next busy vector so outstanding moves in lockstep with busy_mask.
    regfile_scoreboard_popcount #(
        .WIDTH     (NUM_REGS),
        .OUT_WIDTH (ADDR_WIDTH + 1)
    ) u_popcount (
        .i_vec   (busy_d),
        .o_count (outstanding_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q        <= '0;
            outstanding_q <= '0;
            stall_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            busy_q        <= busy_d;
            outstanding_q <= outstanding_d;
            stall_q       <= stall_d;
            err_q         <= err_d;
        end
    end

    assign sb.issue_ready  = ~w_hazard;
    assign sb.busy_mask    = busy_q;
    assign sb.outstanding  = outstanding_q;
    assign sb.stall_cycles = stall_q;
    assign sb.err          = err_q;

endmodule : regfile_scoreboard

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
//==============================================================================
// Module      : tb_regfile_scoreboard
// Description : Self-checking bench for regfile_scoreboard against a busy-set model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_regfile_scoreboard;

    localparam int          NR     = 32;
    localparam int          AW     = 5;
    localparam int          CW     = 8;
    localparam int          BYPASS = 1;
    localparam int unsigned SMAX   = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_scoreboard_if #(.NUM_REGS(NR), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    regfile_scoreboard #(
        .NUM_REGS      (NR),
        .ADDR_WIDTH    (AW),
        .RETIRE_BYPASS (BYPASS),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: the set of registers with a write in flight.
    bit          m_busy [NR];
    bit          m_err;
    int unsigned m_stall;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [NR-1:0] m_mask();
        logic [NR-1:0] m = '0;
        for (int i = 0; i < NR; i++) m[i] = m_busy[i];
        return m;
    endfunction

    function automatic bit m_retiring(int r);
        return (r != 0) && ((bus.wb0_valid && int'(bus.wb0_rd) == r) ||
                            (bus.wb1_valid && int'(bus.wb1_rd) == r));
    endfunction

    function automatic bit m_blocked(int r);
        return (r != 0) && m_busy[r] && !(BYPASS != 0 && m_retiring(r));
    endfunction

    function automatic bit m_ready();
        return !((bus.issue_use_rs1 && m_blocked(int'(bus.issue_rs1))) ||
                 (bus.issue_use_rs2 && m_blocked(int'(bus.issue_rs2))) ||
                 (bus.issue_wr_en   && m_blocked(int'(bus.issue_rd))));
    endfunction

    task automatic m_commit();
        bit rdy = m_ready();
        int a   = int'(bus.wb0_rd);
        int b   = int'(bus.wb1_rd);
        int d   = int'(bus.issue_rd);
        if (bus.issue_valid && !rdy && m_stall < SMAX) m_stall++;
        if (bus.wb0_valid && a != 0 && !m_busy[a]) m_err = 1'b1;
        if (bus.wb1_valid && b != 0 && !m_busy[b]) m_err = 1'b1;
        if (bus.wb0_valid && bus.wb1_valid && a == b && a != 0) m_err = 1'b1;
        if (bus.wb0_valid && a != 0) m_busy[a] = 1'b0;
        if (bus.wb1_valid && b != 0) m_busy[b] = 1'b0;
        if (bus.issue_valid && rdy && bus.issue_wr_en && d != 0) m_busy[d] = 1'b1;
    endtask

    task automatic m_clear();
        for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        m_err   = 1'b0;
        m_stall = 0;
    endtask

    task automatic drive_issue(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit we);
        bus.issue_valid   = v;
        bus.issue_rs1     = AW'(rs1);
        bus.issue_use_rs1 = u1;
        bus.issue_rs2     = AW'(rs2);
        bus.issue_use_rs2 = u2;
        bus.issue_rd      = AW'(rd);
        bus.issue_wr_en   = we;
    endtask

    task automatic drive_wb(bit v0, int r0, bit v1, int r1);
        bus.wb0_valid = v0;
        bus.wb0_rd    = AW'(r0);
        bus.wb1_valid = v1;
        bus.wb1_rd    = AW'(r1);
    endtask

    task automatic idle();
        drive_issue(0, 0, 0, 0, 0, 0, 0);
        drive_wb(0, 0, 0, 0);
    endtask

    task automatic tick();
        m_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        m_clear();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        @(posedge clk);
        #3 rst = 1'b1;
        m_clear();
        #1;
        vectors++;
        if (bus.busy_mask !== '0) begin miscompares++; $display("FAIL reset_busy: got %h expected 0", bus.busy_mask); end
        vectors++;
        if (bus.outstanding !== '0) begin miscompares++; $display("FAIL reset_outstanding: got %0d expected 0", bus.outstanding); end
        vectors++;
        if (bus.err !== 1'b0 || bus.stall_cycles !== '0) begin miscompares++; $display("FAIL reset_err_stall: got err=%b stall=%0d expected 0/0", bus.err, bus.stall_cycles); end
        vectors++;
        if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", bus.issue_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_raw();
        drive_issue(1, 0, 0, 0, 0, 5, 1);
        tick();
        vectors++;
        if (bus.busy_mask !== 32'h0000_0020 || bus.outstanding !== 6'd1) begin miscompares++; $display("FAIL raw_set: got mask=%h out=%0d expected 00000020/1", bus.busy_mask, bus.outstanding); end
        drive_issue(1, 5, 1, 0, 0, 8, 0);
        #1;
        vectors++;
        if (bus.issue_ready !== 1'b0) begin miscompares++; $display("FAIL raw_stall_ready: got %b expected 0", bus.issue_ready); end
        tick();
        tick();
        vectors++;
        if (bus.stall_cycles !== CW'(2)) begin miscompares++; $display("FAIL raw_stall_count: got %0d expected 2", bus.stall_cycles); end
        drive_wb(0, 0, 1, 5);
        #1;
        vectors++;
        if (bus.issue_ready !== 1'(BYPASS != 0)) begin miscompares++; $display("FAIL raw_bypass_ready: got %b expected %b", bus.issue_ready, BYPASS != 0); end
        tick();
        vectors++;
        if (bus.busy_mask !== '0 || bus.stall_cycles !== CW'(m_stall)) begin miscompares++; $display("FAIL raw_retire: got mask=%h stall=%0d expected 0/%0d", bus.busy_mask, bus.stall_cycles, m_stall); end
        idle();
        tick();
    endtask

    task automatic test_x0();
        drive_issue(1, 0, 1, 0, 1, 0, 1);
        #1;
        vectors++;
        if (bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL x0_ready: got %b expected 1", bus.issue_ready); end
        tick();
        tick();
        vectors++;
        if (bus.busy_mask !== '0) begin miscompares++; $display("FAIL x0_busy: got %h expected 0", bus.busy_mask); end
        idle();
        drive_wb(1, 0, 1, 0);
        tick();
        vectors++;
        if (bus.err !== 1'b0) begin miscompares++; $display("FAIL x0_err: got %b expected 0", bus.err); end
        idle();
    endtask

    task automatic test_simultaneous();
        drive_issue(1, 0, 0, 0, 0, 7, 1);
        tick();
        drive_wb(1, 7, 0, 0);
        #1;
        vectors++;
        if (bus.issue_ready !== 1'(BYPASS != 0)) begin miscompares++; $display("FAIL simul_ready: got %b expected %b", bus.issue_ready, BYPASS != 0); end
        tick();
        vectors++;
        if (bus.busy_mask[7] !== 1'b1 || bus.outstanding !== 6'd1 || bus.err !== 1'b0) begin miscompares++; $display("FAIL simul_state: got busy7=%b out=%0d err=%b expected 1/1/0", bus.busy_mask[7], bus.outstanding, bus.err); end
        idle();
        drive_wb(1, 7, 0, 0);
        tick();
        idle();
        tick();
    endtask

    task automatic test_errors();
        drive_wb(1, 3, 0, 0);
        tick();
        idle();
        vectors++;
        if (bus.err !== 1'b1) begin miscompares++; $display("FAIL err_orphan: got %b expected 1", bus.err); end
        tick();
        tick();
        vectors++;
        if (bus.err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b expected 1", bus.err); end
        do_reset();
        drive_issue(1, 0, 0, 0, 0, 9, 1);
        tick();
        idle();
        drive_wb(1, 9, 1, 9);
        tick();
        idle();
        vectors++;
        if (bus.err !== 1'b1 || bus.busy_mask !== '0) begin miscompares++; $display("FAIL err_dual: got err=%b mask=%h expected 1/0", bus.err, bus.busy_mask); end
        do_reset();
    endtask

    task automatic test_back_to_back();
        for (int r = 1; r < NR; r++) begin
            drive_issue(1, r - 1, 0, 0, 0, r, 1);
            tick();
        end
        idle();
        vectors++;
        if (bus.outstanding !== 6'd31 || bus.busy_mask !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL fill_full: got out=%0d mask=%h expected 31/fffffffe", bus.outstanding, bus.busy_mask); end
        for (int k = 0; k < 16; k++) begin
            drive_wb(1, 2 * k + 1, (2 * k + 2) < NR, (2 * k + 2) % NR);
            tick();
            if (k == 7) begin
                vectors++;
                if (bus.outstanding !== 6'd15) begin miscompares++; $display("FAIL fill_half: got %0d expected 15", bus.outstanding); end
            end
        end
        idle();
        vectors++;
        if (bus.outstanding !== '0 || bus.busy_mask !== '0 || bus.err !== 1'b0) begin miscompares++; $display("FAIL fill_drain: got out=%0d mask=%h err=%b expected 0/0/0", bus.outstanding, bus.busy_mask, bus.err); end
    endtask

    task automatic test_stall_saturate();
        drive_issue(1, 0, 0, 0, 0, 4, 1);
        tick();
        drive_issue(1, 0, 0, 4, 1, 0, 0);
        repeat (SMAX + 10) tick();
        vectors++;
        if (bus.stall_cycles !== CW'(SMAX) || bus.issue_ready !== 1'b0) begin miscompares++; $display("FAIL stall_saturate: got stall=%0d ready=%b expected %0d/0", bus.stall_cycles, bus.issue_ready, SMAX); end
        do_reset();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int busy_list[$];
            int pick0, pick1;
            for (int i = 1; i < NR; i++) if (m_busy[i]) busy_list.push_back(i);
            pick0 = (busy_list.size() > 0 && $urandom_range(0, 15) != 0)
                  ? busy_list[$urandom_range(0, busy_list.size() - 1)] : int'($urandom_range(0, NR - 1));
            pick1 = (busy_list.size() > 0 && $urandom_range(0, 15) != 0)
                  ? busy_list[$urandom_range(0, busy_list.size() - 1)] : int'($urandom_range(0, NR - 1));
            drive_issue($urandom_range(0, 3) != 0,
                        int'($urandom_range(0, NR - 1)), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, NR - 1)), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, NR - 1)), 1'($urandom_range(0, 1)));
            drive_wb($urandom_range(0, 2) == 0, pick0, $urandom_range(0, 3) == 0, pick1);
            #1;
            vectors++;
            if (bus.issue_ready !== m_ready()) begin miscompares++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, bus.issue_ready, m_ready()); end
            tick();
            vectors++;
            if (bus.busy_mask !== m_mask() || bus.outstanding !== 6'(m_count())) begin miscompares++; $display("FAIL rand_busy[%0d]: got mask=%h out=%0d expected %h/%0d", n, bus.busy_mask, bus.outstanding, m_mask(), m_count()); end
            vectors++;
            if (bus.stall_cycles !== CW'(m_stall) || bus.err !== m_err) begin miscompares++; $display("FAIL rand_stat[%0d]: got stall=%0d err=%b expected %0d/%b", n, bus.stall_cycles, bus.err, m_stall, m_err); end
        end
        idle();
    endtask

    task automatic test_async_reset();
        drive_issue(1, 0, 0, 0, 0, 12, 1);
        tick();
        drive_issue(1, 12, 1, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (bus.busy_mask !== '0 || bus.outstanding !== '0 || bus.err !== 1'b0 || bus.issue_ready !== 1'b1) begin miscompares++; $display("FAIL async_reset: got mask=%h out=%0d err=%b ready=%b expected 0/0/0/1", bus.busy_mask, bus.outstanding, bus.err, bus.issue_ready); end
        m_clear();
        idle();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_clear();
        idle();
        test_reset();
        test_raw();
        test_x0();
        test_simultaneous();
        test_errors();
        test_back_to_back();
        test_stall_saturate();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_regfile_scoreboard

`default_nettype wire
